id_seg: RTL and testbench
=========================

ID_SEG -- requirements
Module: id_seg

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 1, meaning same-cycle write-back data is forwarded to the A/B read ports.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port NPC  input  32  PC+4 from the fetch stage.
REQ-005 SHALL have port IR  input  32  instruction from the fetch stage.
REQ-006 SHALL have port flush  input  1  branch/jump taken; squash the instruction in ID.
REQ-007 SHALL have ports wbEn/wbAddr/wbData  input  1/5/32  register-file write port.
REQ-008 SHALL have port npcOut  output  32  registered NPC.
REQ-009 SHALL have ports A, B  output  32 each  registered rs, rt operand values.
REQ-010 SHALL have port imm  output  32  registered extended immediate.
REQ-011 SHALL have ports shamt, dest  output  5 each  registered IR[10:6] and destination register.
REQ-012 SHALL have port ctrl  output  12  registered {aluOp[3:0], aluSrc, regWrite, memRead, memWrite, beq, bne, jump, link}.
REQ-013 SHALL have port jumpTarget  output  32  registered {NPC[31:28], IR[25:0], 2'b00}.
REQ-014 SHALL have port illegal  output  1  registered flag: unsupported opcode/funct decoded.
REQ-015 SHALL have port stall  output  1  combinational load-use hazard; fetch holds NPC/IR while high.

Function
REQ-016 SHALL contain a 32x32 register file; r0 reads 0; writes to r0 are discarded; write occurs at the rising edge when wbEn=1.
REQ-017 SHALL, with WB_BYPASS=1, forward wbData to A (B) when wbEn=1, wbAddr!=0 and wbAddr==rs (rt) in the same cycle; with WB_BYPASS=0, read the old value.
REQ-018 SHALL register all outputs with one-cycle latency: IR sampled at edge N appears decoded after edge N.
REQ-019 SHALL decode R-type (opcode 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt, 0x00 sll, 0x02 srl; dest=IR[15:11], regWrite=1, aluSrc=0.
REQ-020 SHALL decode I-type addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23 (regWrite, memRead), sw 0x2B (memWrite); dest=IR[20:16], aluSrc=1.
REQ-021 SHALL decode beq 0x04 / bne 0x05 (aluOp SUB, aluSrc=0, regWrite=0), j 0x02 (jump) and jal 0x03 (jump, link, regWrite=1, dest=31).
REQ-022 SHALL encode aluOp 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 LUI; lw/sw/addi use ADD.
REQ-023 SHALL sign-extend IR[15:0] for addi/lw/sw/beq/bne, zero-extend for andi/ori, and form {IR[15:0],16'h0} for lui.
REQ-024 SHALL treat unknown opcode or R-type funct as a bubble (ctrl=0, dest=0) with illegal=1 for that cycle.
REQ-025 SHALL assert stall when registered ctrl.memRead=1, registered dest!=0, and dest equals rs of the ID instruction, or equals rt when rt is a source (R-type, sw, beq, bne).
REQ-026 SHALL, while stall=1, load a bubble (ctrl=0, dest=0, illegal=0) into the outputs; the held instruction reissues next cycle.
REQ-027 SHALL, when flush=1, load a bubble regardless of IR; flush has priority and forces stall=0.
REQ-028 SHALL pass npcOut, A, B, imm, shamt, jumpTarget through unchanged during bubbles (don't-care downstream).

Reset
REQ-029 SHALL, while rst=1, immediately clear all registered outputs (npcOut, A, B, imm, shamt, dest, ctrl, jumpTarget, illegal) and all 32 registers to 0; stall therefore reads 0.
REQ-030 SHALL, on rst asserted mid-operation, discard any in-flight write-back; first decode occurs at the first rising edge after rst falls.

Verification
REQ-031 SHALL pass: wbEn=1, wbAddr=5, wbData=0x1234; next IR=add r3,r5,r0 -> A=0x1234, B=0, dest=3, aluOp=0, regWrite=1.
REQ-032 SHALL pass: IR=lw r2,-4(r1) then IR=add r4,r2,r2 -> imm=0xFFFFFFFC, memRead=1; stall=1 one cycle, bubble, then add decoded.
REQ-033 SHALL pass: IR=jal with IR[25:0]=0x0000010, NPC=0x40000008 -> jumpTarget=0x40000040, dest=31, jump=link=1.
REQ-034 SHALL pass: flush=1 with lw-use hazard present -> stall=0, ctrl=0, dest=0.
REQ-035 SHALL pass: IR opcode 0x3F -> illegal=1, ctrl=0; write to r0 then read r0 -> A=0.
REQ-036 SHALL pass: rst pulse between edges after loading registers -> all outputs and r1..r31 read 0 immediately.

Source files
------------

// File: rtl/id_seg.sv
// Instruction-decode stage: 32x32 register file, MIPS-subset decoder,
// load-use hazard detection and the ID/EX pipeline register.
module id_seg #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic [31:0] IR,
    input  logic        flush,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic [31:0] npcOut,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] imm,
    output logic [4:0]  shamt,
    output logic [4:0]  dest,
    output logic [11:0] ctrl,
    output logic [31:0] jumpTarget,
    output logic        illegal,
    output logic        stall
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                           ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8;

    logic [31:0] r_rf [32];
    logic [31:0] r_npc, r_a, r_b, r_imm, r_jt;
    logic [4:0]  r_shamt, r_dest;
    logic [11:0] r_ctrl;
    logic        r_illegal;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [3:0]  w_alu_op;
    logic        w_alu_src, w_reg_write, w_mem_read, w_mem_write;
    logic        w_beq, w_bne, w_jump, w_link, w_known, w_rt_src;
    logic [4:0]  w_dest;
    logic [31:0] w_imm, w_a, w_b;
    logic [11:0] w_ctrl;
    logic        w_stall, w_illegal, w_bubble;

    assign w_op    = IR[31:26];
    assign w_rs    = IR[25:21];
    assign w_rt    = IR[20:16];
    assign w_rd    = IR[15:11];
    assign w_funct = IR[5:0];

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_alu_src   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_beq       = 1'b0;
        w_bne       = 1'b0;
        w_jump      = 1'b0;
        w_link      = 1'b0;
        w_dest      = 5'd0;
        w_known     = 1'b1;
        w_imm       = {{16{IR[15]}}, IR[15:0]};
        case (w_op)
            OP_RTYPE: begin
                w_reg_write = 1'b1;
                w_dest      = w_rd;
                case (w_funct)
                    6'h20:   w_alu_op = ALU_ADD;
                    6'h22:   w_alu_op = ALU_SUB;
                    6'h24:   w_alu_op = ALU_AND;
                    6'h25:   w_alu_op = ALU_OR;
                    6'h26:   w_alu_op = ALU_XOR;
                    6'h2A:   w_alu_op = ALU_SLT;
                    6'h00:   w_alu_op = ALU_SLL;
                    6'h02:   w_alu_op = ALU_SRL;
                    default: w_known  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_alu_src = 1'b1; w_reg_write = 1'b1; w_dest = w_rt;
            end
            OP_ANDI: begin
                w_alu_src = 1'b1; w_reg_write = 1'b1; w_dest = w_rt;
                w_alu_op  = ALU_AND; w_imm = {16'h0, IR[15:0]};
            end
            OP_ORI: begin
                w_alu_src = 1'b1; w_reg_write = 1'b1; w_dest = w_rt;
                w_alu_op  = ALU_OR; w_imm = {16'h0, IR[15:0]};
            end
            OP_LUI: begin
                w_alu_src = 1'b1; w_reg_write = 1'b1; w_dest = w_rt;
                w_alu_op  = ALU_LUI; w_imm = {IR[15:0], 16'h0};
            end
            OP_LW: begin
                w_alu_src = 1'b1; w_reg_write = 1'b1; w_mem_read = 1'b1; w_dest = w_rt;
            end
            OP_SW: begin
                w_alu_src = 1'b1; w_mem_write = 1'b1; w_dest = w_rt;
            end
            OP_BEQ: begin
                w_alu_op = ALU_SUB; w_beq = 1'b1;
            end
            OP_BNE: begin
                w_alu_op = ALU_SUB; w_bne = 1'b1;
            end
            OP_J:    w_jump = 1'b1;
            OP_JAL: begin
                w_jump = 1'b1; w_link = 1'b1; w_reg_write = 1'b1; w_dest = 5'd31;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_ctrl = {w_alu_op, w_alu_src, w_reg_write, w_mem_read, w_mem_write,
                     w_beq, w_bne, w_jump, w_link};

    // rt is only a hazard source when the instruction actually reads it.
    assign w_rt_src = (w_op == OP_RTYPE) || (w_op == OP_SW) ||
                      (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_stall  = !flush && r_ctrl[5] && (r_dest != 5'd0) &&
                      ((r_dest == w_rs) || (w_rt_src && (r_dest == w_rt)));
    assign w_illegal = !w_known;
    assign w_bubble  = flush || w_stall || w_illegal;

    assign w_a = (w_rs == 5'd0) ? 32'h0 :
                 (WB_BYPASS && wbEn && (wbAddr == w_rs)) ? wbData : r_rf[w_rs];
    assign w_b = (w_rt == 5'd0) ? 32'h0 :
                 (WB_BYPASS && wbEn && (wbAddr == w_rt)) ? wbData : r_rf[w_rt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wbEn && (wbAddr == 5'(i))) r_rf[i] <= wbData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_npc     <= 32'h0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_imm     <= 32'h0;
            r_jt      <= 32'h0;
            r_shamt   <= 5'd0;
            r_dest    <= 5'd0;
            r_ctrl    <= 12'h0;
            r_illegal <= 1'b0;
        end else begin
            r_npc     <= NPC;
            r_a       <= w_a;
            r_b       <= w_b;
            r_imm     <= w_imm;
            r_jt      <= {NPC[31:28], IR[25:0], 2'b00};
            r_shamt   <= IR[10:6];
            r_dest    <= w_bubble ? 5'd0 : w_dest;
            r_ctrl    <= w_bubble ? 12'h0 : w_ctrl;
            // Only a genuinely decoded illegal instruction flags; squashed ones do not.
            r_illegal <= w_illegal && !flush && !w_stall;
        end
    end

    assign npcOut     = r_npc;
    assign A          = r_a;
    assign B          = r_b;
    assign imm        = r_imm;
    assign shamt      = r_shamt;
    assign dest       = r_dest;
    assign ctrl       = r_ctrl;
    assign jumpTarget = r_jt;
    assign illegal    = r_illegal;
    assign stall      = w_stall;

endmodule

// File: tb/tb_id_seg.sv
// Bench for id_seg: table of decode vectors through an expected queue,
// then hand sequences for load-use stall, flush and asynchronous reset.
module tb_id_seg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] NPC, IR, wbData;
    logic        flush, wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] npcOut, A, B, imm, jumpTarget;
    logic [4:0]  shamt, dest;
    logic [11:0] ctrl;
    logic        illegal, stall;

    int n_checks = 0;
    int n_fail   = 0;

    id_seg dut (
        .clk(clk), .rst(rst), .NPC(NPC), .IR(IR), .flush(flush),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .npcOut(npcOut), .A(A), .B(B), .imm(imm), .shamt(shamt), .dest(dest),
        .ctrl(ctrl), .jumpTarget(jumpTarget), .illegal(illegal), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] npc;
        logic [31:0] ir;
        logic [11:0] e_ctrl;
        logic [4:0]  e_dest;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_ill;
        logic        c_imm;
        logic [31:0] e_imm;
        logic        c_jt;
        logic [31:0] e_jt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic vec_t mk(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [31:0] npc, input logic [31:0] ir,
                                input logic [11:0] e_ctrl, input logic [4:0] e_dest,
                                input logic [31:0] e_a, input logic [31:0] e_b, input logic e_ill,
                                input logic c_imm, input logic [31:0] e_imm,
                                input logic c_jt, input logic [31:0] e_jt);
        vec_t v;
        v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.npc = npc; v.ir = ir;
        v.e_ctrl = e_ctrl; v.e_dest = e_dest; v.e_a = e_a; v.e_b = e_b; v.e_ill = e_ill;
        v.c_imm = c_imm; v.e_imm = e_imm; v.c_jt = c_jt; v.e_jt = e_jt;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic fl, input logic wen, input logic [4:0] waddr,
                          input logic [31:0] wdata, input logic [31:0] npc, input logic [31:0] ir);
        flush = fl; wbEn = wen; wbAddr = waddr; wbData = wdata; NPC = npc; IR = ir;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, then compare the registered result after the next edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        set_in(1'b0, v.wen, v.waddr, v.wdata, v.npc, v.ir);
        exp_q.push_back(v);
        #2;
        check32($sformatf("v%0d_stall", idx), 32'(stall), 32'h0);
        edge1();
        e = exp_q.pop_front();
        check32($sformatf("v%0d_ctrl", idx), 32'(ctrl), 32'(e.e_ctrl));
        check32($sformatf("v%0d_dest", idx), 32'(dest), 32'(e.e_dest));
        check32($sformatf("v%0d_A", idx), A, e.e_a);
        check32($sformatf("v%0d_B", idx), B, e.e_b);
        check32($sformatf("v%0d_illegal", idx), 32'(illegal), 32'(e.e_ill));
        check32($sformatf("v%0d_npc", idx), npcOut, e.npc);
        if (e.c_imm) check32($sformatf("v%0d_imm", idx), imm, e.e_imm);
        if (e.c_jt)  check32($sformatf("v%0d_jt", idx), jumpTarget, e.e_jt);
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_npc"}, npcOut, 32'h0);
        check32({tag, "_A"}, A, 32'h0);
        check32({tag, "_B"}, B, 32'h0);
        check32({tag, "_imm"}, imm, 32'h0);
        check32({tag, "_shamt"}, 32'(shamt), 32'h0);
        check32({tag, "_dest"}, 32'(dest), 32'h0);
        check32({tag, "_ctrl"}, 32'(ctrl), 32'h0);
        check32({tag, "_jt"}, jumpTarget, 32'h0);
        check32({tag, "_illegal"}, 32'(illegal), 32'h0);
        check32({tag, "_stall"}, 32'(stall), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

        //          wen waddr wdata         npc           ir                                  ctrl    dest   A             B             ill c_imm imm           c_jt jt
        vecs.push_back(mk(1, 5'd5,  32'h1234,     32'h1000,     32'h0,                             12'h640, 5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd1,  32'h100,      32'h1004,     r_ins(5, 0, 3, 0, 6'h20),         12'h040, 5'd3,  32'h1234,     32'h0,        0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd6,  32'hABCD,     32'h1008,     r_ins(6, 5, 7, 0, 6'h22),         12'h140, 5'd7,  32'hABCD,     32'h1234,     0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h100C,     r_ins(1, 6, 8, 0, 6'h24),         12'h240, 5'd8,  32'h100,      32'hABCD,     0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1010,     r_ins(5, 1, 9, 0, 6'h2A),         12'h540, 5'd9,  32'h1234,     32'h100,      0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1014,     r_ins(0, 5, 10, 4, 6'h02),        12'h740, 5'd10, 32'h0,        32'h1234,     0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1018,     i_ins(6'h08, 1, 11, 16'hFFFF),    12'h0C0, 5'd11, 32'h100,      32'h0,        0, 1, 32'hFFFFFFFF, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h101C,     i_ins(6'h0C, 6, 12, 16'h8001),    12'h2C0, 5'd12, 32'hABCD,     32'h0,        0, 1, 32'h00008001, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1020,     i_ins(6'h0D, 0, 13, 16'h00F0),    12'h3C0, 5'd13, 32'h0,        32'h0,        0, 1, 32'h000000F0, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1024,     i_ins(6'h0F, 0, 14, 16'h1234),    12'h8C0, 5'd14, 32'h0,        32'h0,        0, 1, 32'h12340000, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1028,     i_ins(6'h2B, 1, 5, 16'h0008),     12'h090, 5'd5,  32'h100,      32'h1234,     0, 1, 32'h00000008, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h102C,     i_ins(6'h04, 5, 6, 16'hFFFE),     12'h108, 5'd0,  32'h1234,     32'hABCD,     0, 1, 32'hFFFFFFFE, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1030,     i_ins(6'h05, 1, 0, 16'h0004),     12'h104, 5'd0,  32'h100,      32'h0,        0, 1, 32'h00000004, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h10000004, j_ins(6'h02, 26'h0000ABC),        12'h002, 5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h10002AF0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h40000008, j_ins(6'h03, 26'h0000010),        12'h043, 5'd31, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h40000040));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1034,     {6'h3F, 26'h0},                   12'h000, 5'd0,  32'h0,        32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1038,     r_ins(1, 5, 9, 0, 6'h3F),         12'h000, 5'd0,  32'h100,      32'h1234,     1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd0,  32'hFFFFFFFF, 32'h103C,     r_ins(0, 0, 15, 0, 6'h20),        12'h040, 5'd15, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        32'h1040,     r_ins(0, 0, 15, 0, 6'h20),        12'h040, 5'd15, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0));

        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Shift amount field.
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h2000, r_ins(0, 5, 10, 7, 6'h00));
        edge1();
        check32("sll_shamt", 32'(shamt), 32'd7);

        // Load-use: lw r2,-4(r1) then add r4,r2,r2 stalls for one bubble.
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h2004, i_ins(6'h23, 1, 2, 16'hFFFC));
        edge1();
        check32("lw_imm", imm, 32'hFFFFFFFC);
        check32("lw_ctrl", 32'(ctrl), 32'h0E0);
        check32("lw_dest", 32'(dest), 32'd2);
        check32("lw_A", A, 32'h100);
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h2008, r_ins(2, 2, 4, 0, 6'h20));
        #2;
        check32("lu_stall_hi", 32'(stall), 32'h1);
        edge1();
        check32("lu_bubble_ctrl", 32'(ctrl), 32'h0);
        check32("lu_bubble_dest", 32'(dest), 32'h0);
        check32("lu_bubble_ill", 32'(illegal), 32'h0);
        check32("lu_stall_lo", 32'(stall), 32'h0);
        edge1();
        check32("lu_add_ctrl", 32'(ctrl), 32'h040);
        check32("lu_add_dest", 32'(dest), 32'd4);

        // rt hazard only when rt is a source operand.
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h200C, i_ins(6'h23, 1, 2, 16'h0000));
        edge1();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h2010, i_ins(6'h2B, 3, 2, 16'h0000));
        #1;
        check32("sw_rt_stall", 32'(stall), 32'h1);
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h2010, i_ins(6'h08, 3, 2, 16'h0001));
        #1;
        check32("addi_rt_nostall", 32'(stall), 32'h0);

        // Flush overrides a pending load-use hazard.
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 32'h2014, r_ins(2, 2, 4, 0, 6'h20));
        #1;
        check32("flush_stall", 32'(stall), 32'h0);
        edge1();
        check32("flush_ctrl", 32'(ctrl), 32'h0);
        check32("flush_dest", 32'(dest), 32'h0);
        check32("flush_ill", 32'(illegal), 32'h0);

        // Asynchronous reset between edges, with a write-back in flight.
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h2018, r_ins(5, 6, 3, 2, 6'h20));
        edge1();
        check32("pre_rst_A", A, 32'h1234);
        set_in(1'b0, 1'b1, 5'd20, 32'hDEADBEEF, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        edge1();
        wbEn = 1'b0;
        rst  = 1'b0;
        for (int r = 1; r < 32; r++) begin
            set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h3000, r_ins(5'(r), 5'(r), 5'd0, 5'd0, 6'h20));
            edge1();
            check32($sformatf("rst_reg%0d", r), A, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
